// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot-product job on a sibling pipelined MAC.
// Latches the job config on start, pulses init_acc, streams operand pairs
// through a valid/ready handshake, waits out the MAC's 2-cycle accumulate
// latency and hands the final sum to the consumer through valid/ready.
module mac_seq_ctrl #(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int LENW = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LENW-1:0] cfg_len,
  input  logic [INW-1:0]  cfg_init,
  output logic            busy,
  input  logic [INW-1:0]  in0,
  input  logic [INW-1:0]  in1,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [INW-1:0]  mac_in0,
  output logic [INW-1:0]  mac_in1,
  output logic [INW-1:0]  mac_init_value,
  output logic            mac_init_acc,
  output logic            mac_input_valid,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] count_q, count_d;
  logic [LENW-1:0] count_inc;
  logic [INW-1:0]  init_q, init_d;
  logic [OUTW-1:0] out_data_q, out_data_d;

  // Operands go to the MAC untouched; the MAC only acts on them when
  // mac_input_valid is high.
  assign mac_in0        = in0;
  assign mac_in1        = in1;
  assign mac_init_value = init_q;
  assign out_data       = out_data_q;

  // count never exceeds len_q - 1 before incrementing, so this cannot wrap.
  assign count_inc = count_q + LENW'(1);

  // State and job registers; a reset drops any partial job.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      init_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      init_q     <= init_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state and job-register update logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    init_d     = init_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          init_d  = cfg_init;
          count_d = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        state_d = (len_q == '0) ? S_DRAIN1 : S_RUN;
      end
      S_RUN: begin
        if (in_valid) begin
          count_d = count_inc;
          if (count_inc == len_q) state_d = S_DRAIN1;
        end
      end
      S_DRAIN1: begin
        // The last product is still in the MAC's multiply stage.
        state_d = S_DRAIN2;
      end
      S_DRAIN2: begin
        // mac_out now holds the complete sum.
        out_data_d = mac_out;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs from state, plus the combinational handshake into the MAC.
  always_comb begin
    busy            = (state_q != S_IDLE);
    in_ready        = 1'b0;
    mac_init_acc    = 1'b0;
    mac_input_valid = 1'b0;
    out_valid       = 1'b0;
    case (state_q)
      S_INIT: mac_init_acc = 1'b1;
      S_RUN: begin
        in_ready        = 1'b1;
        mac_input_valid = in_valid;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl with a behavioural MAC
// alongside it: init_acc loads at the next edge and takes priority, a valid
// product lands in the accumulator two edges after input_valid.
module tb_mac_seq_ctrl;

  localparam int INW  = 16;
  localparam int OUTW = 64;
  localparam int LENW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [LENW-1:0] cfg_len;
  logic [INW-1:0]  cfg_init;
  logic            busy;
  logic [INW-1:0]  in0, in1;
  logic            in_valid;
  logic            in_ready;
  logic [INW-1:0]  mac_in0, mac_in1, mac_init_value;
  logic            mac_init_acc, mac_input_valid;
  logic [OUTW-1:0] mac_out;
  logic [OUTW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mac_seq_ctrl #(.INW(INW), .OUTW(OUTW), .LENW(LENW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_len         (cfg_len),
    .cfg_init        (cfg_init),
    .busy            (busy),
    .in0             (in0),
    .in1             (in1),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .mac_in0         (mac_in0),
    .mac_in1         (mac_in1),
    .mac_init_value  (mac_init_value),
    .mac_init_acc    (mac_init_acc),
    .mac_input_valid (mac_input_valid),
    .mac_out         (mac_out),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural MAC.
  logic signed [63:0] acc = '0;
  logic signed [31:0] prod = '0;
  logic               pv = 1'b0;
  assign mac_out = acc;
  always @(posedge clk) begin
    pv   <= mac_input_valid;
    prod <= $signed(mac_in0) * $signed(mac_in1);
    if (mac_init_acc)
      acc <= {{48{mac_init_value[15]}}, mac_init_value};
    else if (pv)
      acc <= acc + {{32{prod[31]}}, prod};
  end

  // Cycle and pulse counters, sampled at the active edge.
  int cyc = 0, n_iv = 0, n_ia = 0, n_rdy = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_input_valid) n_iv <= n_iv + 1;
    if (mac_init_acc)    n_ia <= n_ia + 1;
    if (in_ready)        n_rdy <= n_rdy + 1;
  end

  int start_cyc, last_hs, done_cyc;
  logic [15:0] p0 [0:7];
  logic [15:0] p1 [0:7];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start for one cycle, checks the INIT cycle, ends in the cycle after INIT.
  task automatic start_job(input int len, input logic [15:0] init);
    start = 1'b1; cfg_len = LENW'(len); cfg_init = init;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    check("init_acc", mac_init_acc, 1);
    check("init_busy", busy, 1);
    check("init_value", mac_init_value, init);
    tick();
  endtask

  // Feeds n pairs following a per-cycle valid mask (1s beyond bit 63).
  task automatic feed(input string tag, input int n, input bit ones, input logic [63:0] vmask);
    int i = 0, k = 0, bad = 0, stray = 0;
    while (i < n && k < 4096) begin
      in_valid = (k < 64) ? vmask[k] : 1'b1;
      in0 = ones ? 16'd1 : p0[i];
      in1 = ones ? 16'd1 : p1[i];
      #1;
      if (in_ready !== 1'b1) bad++;
      if (mac_input_valid !== in_valid) stray++;
      if (mac_in0 !== in0 || mac_in1 !== in1) stray++;
      if (in_valid) begin i++; last_hs = cyc; end
      tick();
      k++;
    end
    in_valid = 1'b0;
    check({tag, "_pairs"}, i, n);
    check({tag, "_ready_low"}, bad, 0);
    check({tag, "_iv_mismatch"}, stray, 0);
    check({tag, "_ready_after"}, in_ready, 0);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (out_valid !== 1'b1 && k < 40) begin tick(); k++; end
    check({tag, "_out_valid"}, out_valid, 1);
    done_cyc = cyc;
  endtask

  task automatic finish_job(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, busy, 0);
  endtask

  int iv0, ia0, rdy0, bad;

  initial begin
    reset = 1'b0; start = 1'b0; cfg_len = '0; cfg_init = '0;
    in0 = '0; in1 = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_init_acc", mac_init_acc, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Job 1: len 3, init 10, back-to-back pairs -> 10+6+20-7 = 29.
    p0[0] = 16'd2; p1[0] = 16'd3;
    p0[1] = 16'd4; p1[1] = 16'd5;
    p0[2] = 16'hFFFF; p1[2] = 16'd7;
    iv0 = n_iv; ia0 = n_ia;
    start_job(3, 16'd10);
    feed("j1", 3, 1'b0, 64'h7);
    wait_done("j1");
    check("j1_latency", done_cyc - last_hs, 3);
    check("j1_data", out_data, 64'd29);
    check("j1_iv_pulses", n_iv - iv0, 3);
    check("j1_ia_pulses", n_ia - ia0, 1);
    finish_job("j1");

    // Job 2: same job with gaps, valid on RUN cycles 0,3,4.
    iv0 = n_iv;
    start_job(3, 16'd10);
    feed("j2", 3, 1'b0, 64'b11001);
    wait_done("j2");
    check("j2_latency", done_cyc - last_hs, 3);
    check("j2_data", out_data, 64'd29);
    check("j2_iv_pulses", n_iv - iv0, 3);
    finish_job("j2");

    // Job 3: len 0, init -5.
    rdy0 = n_rdy;
    start_job(0, 16'hFFFB);
    wait_done("j3");
    check("j3_latency", done_cyc - start_cyc, 4);
    check("j3_data", out_data, 64'hFFFF_FFFF_FFFF_FFFB);
    check("j3_no_ready", n_rdy - rdy0, 0);
    finish_job("j3");

    // Job 4: consumer stalls 5 cycles in DONE while start pulses.
    p0[0] = 16'd6; p1[0] = 16'd7;
    start_job(1, 16'd0);
    feed("j4", 1, 1'b0, 64'h1);
    wait_done("j4");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      cfg_len = 10'd3; cfg_init = 16'd99;
      tick();
      if (out_valid !== 1'b1 || out_data !== 64'd42 || busy !== 1'b1) bad++;
    end
    start = 1'b0;
    check("j4_hold", bad, 0);
    finish_job("j4");
    tick();
    check("j4_no_queued_start", busy, 0);

    // Jobs 5/6: start held high gives back-to-back jobs.
    p0[0] = 16'd2; p1[0] = 16'd3;
    p0[1] = 16'd4; p1[1] = 16'd5;
    p0[2] = 16'hFFFF; p1[2] = 16'd7;
    start = 1'b1; cfg_len = 10'd3; cfg_init = 16'd10;
    tick();
    check("j5_init_acc", mac_init_acc, 1);
    tick();
    feed("j5", 3, 1'b0, 64'h7);
    wait_done("j5");
    check("j5_data", out_data, 64'd29);
    cfg_len = 10'd1; cfg_init = 16'd100;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("j5_idle", busy, 0);
    tick();
    start = 1'b0;
    check("j6_init_acc", mac_init_acc, 1);
    check("j6_init_value", mac_init_value, 16'd100);
    tick();
    p0[0] = 16'd2; p1[0] = 16'd2;
    feed("j6", 1, 1'b0, 64'h1);
    wait_done("j6");
    check("j6_data", out_data, 64'd104);
    finish_job("j6");

    // Job 7: reset mid-RUN after 2 of 3 pairs.
    p0[0] = 16'd2; p1[0] = 16'd3;
    p0[1] = 16'd4; p1[1] = 16'd5;
    start_job(3, 16'd10);
    in_valid = 1'b1; in0 = p0[0]; in1 = p1[0]; tick();
    in0 = p0[1]; in1 = p1[1]; tick();
    in0 = 16'hFFFF; in1 = 16'd7;
    #2;
    reset = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_out_data", out_data, 0);
    check("ar_in_ready", in_ready, 0);
    check("ar_input_valid", mac_input_valid, 0);
    check("ar_init_value", mac_init_value, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    p0[0] = 16'd3; p1[0] = 16'd3;
    p0[1] = 16'd1; p1[1] = 16'd1;
    start_job(2, 16'd0);
    feed("j7", 2, 1'b0, 64'h3);
    wait_done("j7");
    check("j7_data", out_data, 64'd10);
    finish_job("j7");

    // Job 8: maximum length, all ones.
    start_job(1023, 16'd0);
    feed("j8", 1023, 1'b1, '1);
    wait_done("j8");
    check("j8_latency", done_cyc - last_hs, 3);
    check("j8_data", out_data, 64'd1023);
    finish_job("j8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
